// File: rtl/aes128_pkg.sv
// aes128_pkg: shared types and constants for the AES-128 accelerator read path.
package aes128_pkg;
  typedef enum logic [2:0] {IDLE, FETCH_KEY, WAIT_KEY, FETCH, DRAIN, DONE} t_rd_sched_state;
  localparam logic [15:0] KEY_MDATA = 16'h8000;
endpackage

// File: rtl/aes128_rd_sched.sv
// aes128_rd_sched: fetches the key line, then streams source lines over CCI-P c0 under an outstanding cap.
// AES128_RD_SCHED_STATS_EN adds a saturating almost-full stall counter on stat_stall.
module aes128_rd_sched
  import aes128_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int SIZE_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [41:0]       key_addr,
  input  logic [41:0]       src_addr,
  input  logic [SIZE_W-1:0] src_lines,
  input  logic              c0_almfull,
  output logic              rd_req_valid,
  output logic [41:0]       rd_req_addr,
  output logic [15:0]       rd_req_mdata,
  input  logic              rd_rsp_valid,
  input  logic [15:0]       rd_rsp_mdata,
  input  logic [511:0]      rd_rsp_data,
  output logic              key_valid,
  output logic [127:0]      key,
  output logic              blk_valid,
  output logic [SIZE_W-1:0] blk_idx,
  output logic [511:0]      blk_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       stat_stall
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  t_rd_sched_state state_q, state_d;
  logic [SIZE_W-1:0] lines_q, lines_d, issued_q, issued_d, blk_idx_q, blk_idx_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [41:0] key_addr_q, key_addr_d, src_addr_q, src_addr_d, req_addr_q, req_addr_d;
  logic [15:0] req_mdata_q, req_mdata_d;
  logic [127:0] key_q, key_d;
  logic [511:0] blk_data_q, blk_data_d;
  logic key_pend_q, key_pend_d, req_valid_q, req_valid_d, key_valid_q, key_valid_d;
  logic blk_valid_q, blk_valid_d, aborted_q, aborted_d;
  logic can_issue, issue, key_issue, rsp_key, rsp_src;
  always_comb begin
    can_issue = state_q == FETCH && !stop && outst_q < OW'(MAX_OUTSTANDING) && issued_q < lines_q;
    issue = can_issue && !c0_almfull;
    key_issue = state_q == FETCH_KEY && !stop && !c0_almfull;
    rsp_key = rd_rsp_valid && rd_rsp_mdata == KEY_MDATA && state_q != IDLE;
    rsp_src = rd_rsp_valid && !rd_rsp_mdata[15] && state_q != IDLE;
    state_d = state_q;
    lines_d = lines_q;
    issued_d = issue ? issued_q + SIZE_W'(1) : issued_q;
    outst_d = outst_q + OW'(issue) - OW'(rsp_src && outst_q != '0);
    key_addr_d = key_addr_q;
    src_addr_d = src_addr_q;
    req_valid_d = issue || key_issue;
    req_addr_d = key_issue ? key_addr_q : issue ? src_addr_q + 42'(issued_q) : req_addr_q;
    req_mdata_d = key_issue ? KEY_MDATA : issue ? 16'(issued_q) : req_mdata_q;
    key_pend_d = key_issue ? 1'b1 : rsp_key ? 1'b0 : key_pend_q;
    key_valid_d = rsp_key && state_q == WAIT_KEY;
    key_d = key_valid_d ? rd_rsp_data[127:0] : key_q;
    blk_valid_d = rsp_src;
    blk_idx_d = rsp_src ? rd_rsp_mdata[SIZE_W-1:0] : blk_idx_q;
    blk_data_d = rsp_src ? rd_rsp_data : blk_data_q;
    aborted_d = aborted_q | (stop && state_q inside {FETCH_KEY, WAIT_KEY, FETCH, DRAIN});
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH_KEY;
        lines_d = src_lines;
        issued_d = '0;
        outst_d = '0;
        key_addr_d = key_addr;
        src_addr_d = src_addr;
        key_pend_d = 1'b0;
        aborted_d = 1'b0;
      end
      FETCH_KEY: state_d = key_issue ? WAIT_KEY : FETCH_KEY;
      WAIT_KEY:  state_d = !rsp_key ? WAIT_KEY : lines_q == '0 ? DONE : FETCH;
      FETCH:     state_d = issued_q == lines_q ? DRAIN : FETCH;
      DRAIN:     state_d = outst_q == '0 && !key_pend_q ? DONE : DRAIN;
      default:   state_d = IDLE;
    endcase
    // An abort still waits for in-flight reads, including a pending key read
    if (stop && state_q inside {FETCH_KEY, WAIT_KEY, FETCH}) state_d = DRAIN;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      lines_q <= '0;
      issued_q <= '0;
      outst_q <= '0;
      key_addr_q <= '0;
      src_addr_q <= '0;
      req_valid_q <= 1'b0;
      req_addr_q <= '0;
      req_mdata_q <= '0;
      key_pend_q <= 1'b0;
      key_valid_q <= 1'b0;
      key_q <= '0;
      blk_valid_q <= 1'b0;
      blk_idx_q <= '0;
      blk_data_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lines_q <= lines_d;
      issued_q <= issued_d;
      outst_q <= outst_d;
      key_addr_q <= key_addr_d;
      src_addr_q <= src_addr_d;
      req_valid_q <= req_valid_d;
      req_addr_q <= req_addr_d;
      req_mdata_q <= req_mdata_d;
      key_pend_q <= key_pend_d;
      key_valid_q <= key_valid_d;
      key_q <= key_d;
      blk_valid_q <= blk_valid_d;
      blk_idx_q <= blk_idx_d;
      blk_data_q <= blk_data_d;
      aborted_q <= aborted_d;
    end
`ifdef AES128_RD_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d;
  always_comb
    stall_d = state_q == IDLE && start ? '0 :
              can_issue && c0_almfull && stall_q != '1 ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_q <= '0;
    else stall_q <= stall_d;
  assign stat_stall = stall_q;
`else
  assign stat_stall = 32'h0;
`endif
  assign rd_req_valid = req_valid_q;
  assign rd_req_addr = req_addr_q;
  assign rd_req_mdata = req_mdata_q;
  assign key_valid = key_valid_q;
  assign key = key_q;
  assign blk_valid = blk_valid_q;
  assign blk_idx = blk_idx_q;
  assign blk_data = blk_data_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign aborted = aborted_q;
endmodule
